// File: rtl/mul_arbiter_pkg.sv
// Shared encodings for the two-requester multiplier arbiter: FSM states and requester IDs.
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mul_arbiter_if.sv
// Request/response handshake bundle between two requesters and the shared multiplier arbiter.
interface mul_arbiter_if #(
    parameter int N = 32
);
    logic           req0_valid;
    logic           req0_ready;
    logic [N-1:0]   req0_x;
    logic [N-1:0]   req0_y;
    logic           req1_valid;
    logic           req1_ready;
    logic [N-1:0]   req1_x;
    logic [N-1:0]   req1_y;
    logic           resp0_valid;
    logic           resp0_ready;
    logic [2*N-1:0] resp0_p;
    logic           resp1_valid;
    logic           resp1_ready;
    logic [2*N-1:0] resp1_p;
    logic           busy;

    modport slave (
        input  req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        input  resp0_ready, resp1_ready,
        output req0_ready, req1_ready, resp0_valid, resp0_p, resp1_valid, resp1_p, busy
    );

    modport master (
        output req0_valid, req0_x, req0_y, req1_valid, req1_x, req1_y,
        output resp0_ready, resp1_ready,
        input  req0_ready, req1_ready, resp0_valid, resp0_p, resp1_valid, resp1_p, busy
    );
endinterface

// File: rtl/mul_arbiter_radix4acc.sv
// Combinational unsigned radix-4 Booth multiplier, exact 2N-bit product; no latency, no handshake.
module radix4acc #(
    parameter int N = 32
) (
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [2*N-1:0] p
);
    // Unsigned operand: pad y with zeros so the top Booth digit never sees a set sign bit.
    localparam int YW = (N % 2 == 0) ? N + 2 : N + 1;
    localparam int D  = YW / 2;

    logic [YW:0]    ypad;
    logic [2*N-1:0] xw;
    logic [2*N-1:0] pp;
    logic [2*N-1:0] acc;
    logic [2:0]     trip;

    always_comb begin
        ypad = {{(YW - N){1'b0}}, y, 1'b0};
        xw   = {{N{1'b0}}, x};
        acc  = '0;
        pp   = '0;
        trip = '0;
        for (int i = 0; i < D; i++) begin
            trip = ypad[2*i +: 3];
            case (trip)
                3'b001, 3'b010: pp = xw;
                3'b011:         pp = xw << 1;
                3'b100:         pp = -(xw << 1);
                3'b101, 3'b110: pp = -xw;
                default:        pp = '0;
            endcase
            // Modulo-2^(2N) wraparound keeps negative digits exact for the final unsigned sum.
            acc = acc + (pp << (2*i));
        end
        p = acc;
    end
endmodule

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one Booth multiplier between two requesters; response 2 cycles after accept.
// One operation in flight; ready is withheld outside IDLE and the response holds until the owner takes it.
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mul_arbiter_if.slave  bus
);
    state_t         state, state_nxt;
    logic           last_grant;
    logic           owner;
    logic           gnt_id;
    logic           accept;
    logic           owner_ready;
    logic [N-1:0]   op_x;
    logic [N-1:0]   op_y;
    logic [2*N-1:0] res_p;
    logic [2*N-1:0] mul_p;

    radix4acc #(.N(N)) u_mul (
        .x (op_x),
        .y (op_y),
        .p (mul_p)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt       = state;
        gnt_id          = REQ0;
        accept          = 1'b0;
        owner_ready     = (owner == REQ0) ? bus.resp0_ready : bus.resp1_ready;
        bus.req0_ready  = 1'b0;
        bus.req1_ready  = 1'b0;
        bus.resp0_valid = 1'b0;
        bus.resp1_valid = 1'b0;
        bus.resp0_p     = '0;
        bus.resp1_p     = '0;
        bus.busy        = 1'b0;

        // On a tie the requester that did not win last time goes first.
        if (bus.req0_valid && bus.req1_valid) gnt_id = (last_grant == REQ0) ? REQ1 : REQ0;
        else if (bus.req1_valid)              gnt_id = REQ1;

        if (rst_n) begin
            bus.busy = (state != IDLE);
            case (state)
                IDLE: begin
                    accept = bus.req0_valid || bus.req1_valid;
                    if (accept) begin
                        bus.req0_ready = (gnt_id == REQ0);
                        bus.req1_ready = (gnt_id == REQ1);
                        state_nxt      = CALC;
                    end
                end
                CALC: state_nxt = HOLD;
                HOLD: begin
                    bus.resp0_valid = (owner == REQ0);
                    bus.resp1_valid = (owner == REQ1);
                    bus.resp0_p     = (owner == REQ0) ? res_p : '0;
                    bus.resp1_p     = (owner == REQ1) ? res_p : '0;
                    if (owner_ready) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= REQ1;
            owner      <= REQ0;
            op_x       <= '0;
            op_y       <= '0;
            res_p      <= '0;
        end else begin
            if (accept) begin
                last_grant <= gnt_id;
                owner      <= gnt_id;
                op_x       <= (gnt_id == REQ1) ? bus.req1_x : bus.req0_x;
                op_y       <= (gnt_id == REQ1) ? bus.req1_y : bus.req0_y;
            end
            if (state == CALC) res_p <= mul_p;
        end
    end
endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: vector table of single operations plus tie, stall and reset sequences.
module tb_mul_arbiter;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mul_arbiter_if #(.N(32)) bus ();

    mul_arbiter #(.N(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        sel;
        logic [31:0] x;
        logic [31:0] y;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req0_valid  = 1'b0;
        bus.req1_valid  = 1'b0;
        bus.req0_x      = '0;
        bus.req0_y      = '0;
        bus.req1_x      = '0;
        bus.req1_y      = '0;
        bus.resp0_ready = 1'b0;
        bus.resp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        next_cyc();
        rst_n          = 1'b0;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        @(negedge clk);
        chk("rst_req0_ready", {63'd0, bus.req0_ready}, 64'd0);
        chk("rst_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_resp_valid", {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
        chk("rst_resp_p", bus.resp0_p | bus.resp1_p, 64'd0);
        next_cyc();
        idle_inputs();
        rst_n = 1'b1;
    endtask

    // Starts at +1 of a cycle with the DUT in IDLE; leaves it in IDLE at +1 of a later cycle.
    task automatic run_op(input int idx, input logic sel, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] p);
        if (sel) begin
            bus.req1_valid = 1'b1; bus.req1_x = x; bus.req1_y = y;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_x = x; bus.req0_y = y;
        end
        @(negedge clk);
        chk($sformatf("v%0d_ready_T", idx), {62'd0, bus.req1_ready, bus.req0_ready},
            sel ? 64'd2 : 64'd1);
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_valid_T1", idx), {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
        chk($sformatf("v%0d_busy_T1", idx), {63'd0, bus.busy}, 64'd1);
        next_cyc();
        @(negedge clk);
        chk($sformatf("v%0d_valid_T2", idx), {62'd0, bus.resp1_valid, bus.resp0_valid},
            sel ? 64'd2 : 64'd1);
        chk($sformatf("v%0d_p", idx), sel ? bus.resp1_p : bus.resp0_p, p);
        chk($sformatf("v%0d_other_p", idx), sel ? bus.resp0_p : bus.resp1_p, 64'd0);
        if (sel) bus.resp1_ready = 1'b1;
        else     bus.resp0_ready = 1'b1;
        next_cyc();
        idle_inputs();
        @(negedge clk);
        chk($sformatf("v%0d_busy_done", idx), {63'd0, bus.busy}, 64'd0);
        next_cyc();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        idle_inputs();

        vecs[0] = '{1'b0, 32'd3,          32'd5,          64'd15};
        vecs[1] = '{1'b1, 32'hFFFFFFFF,   32'hFFFFFFFF,   64'hFFFFFFFE00000001};
        vecs[2] = '{1'b0, 32'h12345678,   32'h0,          64'd0};
        vecs[3] = '{1'b1, 32'h0,          32'h9ABCDEF0,   64'd0};
        vecs[4] = '{1'b1, 32'd7,          32'd6,          64'd42};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000FFFFFFFF};
        vecs[6] = '{1'b1, 32'h80000000,   32'd2,          64'h0000000100000000};
        vecs[7] = '{1'b0, 32'h0000FFFF,   32'h0000FFFF,   64'h00000000FFFE0001};
        vecs[8] = '{1'b1, 32'hAAAAAAAA,   32'd3,          64'h00000001FFFFFFFE};
        vecs[9] = '{1'b0, 32'd5,          32'hFFFFFFFF,   64'h00000004FFFFFFFB};

        do_reset();
        for (int i = 0; i < 10; i++) run_op(i, vecs[i].sel, vecs[i].x, vecs[i].y, vecs[i].p);

        // Tie straight after reset: 0 first, then alternating while both stay valid.
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_x = 32'd7; bus.req0_y = 32'd6;
        bus.req1_valid = 1'b1; bus.req1_x = 32'd9; bus.req1_y = 32'd9;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("tie%0d_grant", k), {62'd0, bus.req1_ready, bus.req0_ready},
                (k % 2 == 0) ? 64'd1 : 64'd2);
            next_cyc();
            next_cyc();
            @(negedge clk);
            chk($sformatf("tie%0d_valid", k), {62'd0, bus.resp1_valid, bus.resp0_valid},
                (k % 2 == 0) ? 64'd1 : 64'd2);
            chk($sformatf("tie%0d_p", k), (k % 2 == 0) ? bus.resp0_p : bus.resp1_p,
                (k % 2 == 0) ? 64'd42 : 64'd81);
            bus.resp0_ready = (k % 2 == 0);
            bus.resp1_ready = (k % 2 == 1);
            next_cyc();
            bus.resp0_ready = 1'b0;
            bus.resp1_ready = 1'b0;
        end
        idle_inputs();
        next_cyc();

        // Owner stalls in HOLD while the other requester waits.
        bus.req0_valid = 1'b1; bus.req0_x = 32'd4; bus.req0_y = 32'd4;
        next_cyc();
        idle_inputs();
        next_cyc();
        bus.req1_valid = 1'b1; bus.req1_x = 32'd9; bus.req1_y = 32'd9;
        bus.resp1_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", c), {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd1);
            chk($sformatf("stall%0d_p", c), bus.resp0_p, 64'd16);
            chk($sformatf("stall%0d_busy", c), {63'd0, bus.busy}, 64'd1);
            chk($sformatf("stall%0d_req1_ready", c), {63'd0, bus.req1_ready}, 64'd0);
            next_cyc();
        end
        bus.resp1_ready = 1'b0;
        bus.resp0_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
        next_cyc();
        bus.resp0_ready = 1'b0;
        @(negedge clk);
        chk("after_stall_req1_ready", {63'd0, bus.req1_ready}, 64'd1);
        next_cyc();
        bus.req1_valid = 1'b0;
        next_cyc();
        @(negedge clk);
        chk("after_stall_resp1_p", bus.resp1_p, 64'd81);
        bus.resp1_ready = 1'b1;
        next_cyc();
        idle_inputs();

        // Reset in CALC aborts the operation.
        bus.req0_valid = 1'b1; bus.req0_x = 32'd2; bus.req0_y = 32'd2;
        @(negedge clk);
        chk("abort_accept", {63'd0, bus.req0_ready}, 64'd1);
        next_cyc();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy_in_rst", {63'd0, bus.busy}, 64'd0);
        chk("abort_outs_in_rst", {61'd0, bus.resp1_valid, bus.resp0_valid, bus.req0_ready}, 64'd0);
        next_cyc();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("abort%0d_busy", c), {63'd0, bus.busy}, 64'd0);
            chk($sformatf("abort%0d_valid", c), {62'd0, bus.resp1_valid, bus.resp0_valid}, 64'd0);
            chk($sformatf("abort%0d_p", c), bus.resp0_p, 64'd0);
            next_cyc();
        end
        run_op(99, 1'b0, 32'd3, 32'd5, 64'd15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter N, default 32, operand width; the product width is 2N.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-004 req0_valid / req1_valid  input  1  requester r presents an operand pair.
REQ-005 req0_ready / req1_ready  output  1  the arbiter accepts the pair from requester r this cycle.
REQ-006 req0_x, req0_y / req1_x, req1_y  input  N  unsigned multiplicand and multiplier.
REQ-007 resp0_valid / resp1_valid  output  1  the product for requester r is available.
REQ-008 resp0_ready / resp1_ready  input  1  requester r consumes the product.
REQ-009 resp0_p / resp1_p  output  2N  unsigned product x*y.
REQ-010 busy  output  1  high in every state other than IDLE.

Function
REQ-011 The block shall share one radix-4 Booth multiplier instance between two requesters, with at most one operation in flight.
REQ-012 The FSM shall have three states, IDLE, CALC and HOLD, and shall reset to IDLE.
REQ-013 In IDLE with exactly one reqN_valid high, that requester shall be granted: its ready goes high combinationally, and its operands and ID are captured into op_x, op_y and owner; the next state is CALC.
REQ-014 In IDLE with both valids high, the requester other than last_grant shall be granted; last_grant shall update to the granted ID on every accepted request.
REQ-015 Both req*_ready outputs shall be 0 in CALC and HOLD, and also in IDLE when no request is valid.
REQ-016 In CALC the multiplier output, computed from op_x and op_y, shall be registered into res_p; the next state is HOLD.
REQ-017 In HOLD only the owner's respN_valid shall be high, and its respN_p shall equal res_p.
REQ-018 The HOLD response shall stay stable until the owner's respN_ready is high, after which the next state is IDLE.
REQ-019 The non-owner's ready shall be ignored in HOLD.
REQ-020 respN_p shall be 0 whenever respN_valid is low.
REQ-021 Latency: a request accepted in cycle T shall produce respN_valid in cycle T+2.
REQ-022 Minimum issue interval is 3 cycles per operation.
REQ-023 A new request shall not be accepted in the cycle in which a response completes.
REQ-024 The product shall be the exact unsigned value x*y, modulo 2^(2N), with no truncation.
REQ-025 Boundary: x=0 or y=0 shall yield 0.
REQ-026 Boundary: all-ones operands shall yield the full 2N-bit result.
REQ-027 Any reqN_valid deassertion without a handshake shall have no effect.

Reset
REQ-028 While rst_n=0 at a clock edge: state goes to IDLE, last_grant=1 (so requester 0 wins the first tie), owner=0, res_p=0, op_x=op_y=0.
REQ-029 While rst_n=0, all outputs shall be 0.
REQ-030 Reset asserted in CALC or HOLD shall abort the operation with no response delivered, and IDLE shall follow the next edge with rst_n=1.

Structure
REQ-031 A shared package shall hold the state encoding (IDLE=2'd0, CALC=2'd1, HOLD=2'd2) and the requester-ID constants.
REQ-032 There shall be exactly one sub-module: radix4acc, instantiated with N, fed from op_x and op_y, and purely combinational.
REQ-033 All arbitration and FSM logic shall reside in mul_arbiter.

Verification
REQ-034 After reset, req0 with x=3, y=5 -> req0_ready=1 at T, resp0_valid=1 at T+2 with resp0_p=15, resp1_valid=0 throughout.
REQ-035 req1 with x=y=0xFFFFFFFF -> resp1_p=0xFFFFFFFE00000001.
REQ-036 First cycle after reset with both valid (req0: 7*6, req1: 9*9) -> req0 granted first with resp0_p=42, then req1 granted with resp1_p=81; with both kept valid afterwards, grants alternate 0,1,0,1.
REQ-037 resp0_ready held low 10 cycles in HOLD -> resp0_valid and resp0_p stay stable, busy=1, req1_ready=0 despite req1_valid=1.
REQ-038 rst_n=0 during CALC (x=2, y=2) -> no response delivered, all outputs 0, busy=0 the cycle after release.
REQ-039 x=0x12345678, y=0 and x=0, y=0x9ABCDEF0 -> product 0 in each case.
